// File: rtl/pc_unit_if.sv
//------------------------------------------------------------------------------
// Module   : pc_unit_if
// Brief    : Control-side strobes, targets and PC/RAS status for pc_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int OFF_W     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             enable;
  logic             inc;
  logic             ld;
  logic             br;
  logic             br_cond;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] d;
  logic [OFF_W-1:0] offset;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_full;
  logic             ras_empty;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output enable, inc, ld, br, br_cond, call, ret, d, offset,
    input  q, ras_cnt, ras_full, ras_empty, ras_ovf, ras_unf
  );

  modport slave (
    input  enable, inc, ld, br, br_cond, call, ret, d, offset,
    output q, ras_cnt, ras_full, ras_empty, ras_ovf, ras_unf
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
//------------------------------------------------------------------------------
// Module   : pc_unit
// Brief    : Program counter with inc/load/branch and an optional circular
//            return-address stack, enabled by defining PC_RAS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int          WIDTH     = 32,
  parameter longint unsigned RESET_VAL = 0,
  parameter longint unsigned STEP      = 1,
  parameter int          OFF_W     = 16,
  parameter int          RAS_DEPTH = 4
) (
  input  wire logic  clk,
  input  wire logic  clr,
  pc_unit_if.slave   bus
);
  localparam int               c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_step  = WIDTH'(STEP);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_pc_step;
  logic [WIDTH-1:0] w_off_ext;
  logic             w_br_taken;

  // Casting the signed offset up to WIDTH performs the sign extension.
  assign w_off_ext  = WIDTH'($signed(bus.offset));
  assign w_pc_step  = r_q + c_step;
  assign w_br_taken = bus.br && bus.br_cond;
  assign bus.q      = r_q;

`ifdef PC_RAS_EN
  localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_sp;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ovf;
  logic               r_unf;
  logic [c_ptr_w-1:0] w_top_idx;
  logic [c_ptr_w-1:0] w_sp_next;
  logic               w_full;
  logic               w_empty;
  logic               w_push;

  // r_sp is the next slot to write; when full that slot holds the oldest entry.
  assign w_top_idx = (r_sp == '0) ? c_ptr_w'(RAS_DEPTH - 1) : r_sp - 1'b1;
  assign w_sp_next = (r_sp == c_ptr_w'(RAS_DEPTH - 1)) ? '0 : r_sp + 1'b1;
  assign w_full    = (r_cnt == c_cnt_w'(RAS_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = !clr && bus.enable && !bus.ret && bus.call;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= w_pc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q   <= c_reset;
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.enable) begin
      if (bus.ret) begin
        if (!w_empty) begin
          r_q   <= r_ras[w_top_idx];
          r_sp  <= w_top_idx;
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_q   <= w_pc_step;
          r_unf <= 1'b1;
        end
      end else if (bus.call) begin
        r_q  <= bus.d;
        r_sp <= w_sp_next;
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (bus.ld) begin
        r_q <= bus.d;
      end else if (w_br_taken) begin
        r_q <= r_q + w_off_ext;
      end else if (bus.inc) begin
        r_q <= w_pc_step;
      end
    end
  end

  assign bus.ras_cnt   = r_cnt;
  assign bus.ras_full  = w_full;
  assign bus.ras_empty = w_empty;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;
`else
  // Without a stack, ret has no meaning and call degenerates to a load.
  logic w_unused_ret;
  assign w_unused_ret = bus.ret;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= c_reset;
    end else if (bus.enable) begin
      if (bus.call || bus.ld) begin
        r_q <= bus.d;
      end else if (w_br_taken) begin
        r_q <= r_q + w_off_ext;
      end else if (bus.inc) begin
        r_q <= w_pc_step;
      end
    end
  end

  assign bus.ras_cnt   = '0;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_ovf   = 1'b0;
  assign bus.ras_unf   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_unit
// Brief    : Vector-table and scoreboard bench for pc_unit (both PC_RAS_EN builds).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;
  localparam logic [7:0] S_CLR  = 8'h80;
  localparam logic [7:0] S_EN   = 8'h40;
  localparam logic [7:0] S_INC  = 8'h20;
  localparam logic [7:0] S_LD   = 8'h10;
  localparam logic [7:0] S_BR   = 8'h08;
  localparam logic [7:0] S_BC   = 8'h04;
  localparam logic [7:0] S_CALL = 8'h02;
  localparam logic [7:0] S_RET  = 8'h01;

  typedef struct {
    logic [7:0]  st;
    logic [31:0] d;
    logic [15:0] off;
    logic [31:0] eq;
    logic [2:0]  ecnt;
    logic        eovf;
    logic        eunf;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32), .OFF_W(16), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH(32), .RESET_VAL(64'h100), .STEP(64'd1), .OFF_W(16), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_q;
  bit          have_prev = 0;

  function automatic vec_t mk(input logic [7:0] st, input logic [31:0] d,
                              input logic [15:0] off, input logic [31:0] eq,
                              input logic [2:0] ecnt, input logic eovf, input logic eunf);
    vec_t v;
    v.st = st; v.d = d; v.off = off; v.eq = eq;
    v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic add(input logic [7:0] st, input logic [31:0] d, input logic [15:0] off,
                     input logic [31:0] eq, input logic [2:0] ecnt,
                     input logic eovf, input logic eunf);
    tbl.push_back(mk(st, d, off, eq, ecnt, eovf, eunf));
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  int step_no = 0;

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    clr         = v.st[7];
    bus.enable  = v.st[6];
    bus.inc     = v.st[5];
    bus.ld      = v.st[4];
    bus.br      = v.st[3];
    bus.br_cond = v.st[2];
    bus.call    = v.st[1];
    bus.ret     = v.st[0];
    bus.d       = v.d;
    bus.offset  = v.off;
    sb.push_back(v);
    #1;
    if (have_prev) chk("q_stable_before_edge", step_no, bus.q, prev_q);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q",         step_no, bus.q,                 e.eq);
    chk("ras_cnt",   step_no, 32'(bus.ras_cnt),      32'(e.ecnt));
    chk("ras_full",  step_no, 32'(bus.ras_full),     32'(e.ecnt == 3'd4));
    chk("ras_empty", step_no, 32'(bus.ras_empty),    32'(e.ecnt == 3'd0));
    chk("ras_ovf",   step_no, 32'(bus.ras_ovf),      32'(e.eovf));
    chk("ras_unf",   step_no, 32'(bus.ras_unf),      32'(e.eunf));
    prev_q    = e.eq;
    have_prev = 1;
    step_no++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable = 0; bus.inc = 0; bus.ld = 0; bus.br = 0; bus.br_cond = 0;
    bus.call = 0; bus.ret = 0; bus.d = '0; bus.offset = '0;

    // Increment, enable gating, branch and wrap behaviour common to both builds.
    add(S_CLR,                    0, 0,       32'h100, 0, 0, 0);
    add(S_EN|S_INC,               0, 0,       32'h101, 0, 0, 0);
    add(S_EN|S_INC,               0, 0,       32'h102, 0, 0, 0);
    add(S_EN|S_INC,               0, 0,       32'h103, 0, 0, 0);
    add(S_INC,                    0, 0,       32'h103, 0, 0, 0);
    add(S_EN|S_LD,                32'h200, 0, 32'h200, 0, 0, 0);
    add(S_EN|S_BR|S_BC,           0, 16'hFFF0, 32'h1F0, 0, 0, 0);
    add(S_EN|S_BR|S_INC,          0, 16'hFFF0, 32'h1F1, 0, 0, 0);
    add(S_EN|S_BR,                0, 16'h0040, 32'h1F1, 0, 0, 0);
    add(S_EN|S_LD,                32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0);
    add(S_EN|S_INC,               0, 0,       32'h0,   0, 0, 0);
    add(S_EN|S_LD,                32'h10, 0,  32'h10,  0, 0, 0);
`ifdef PC_RAS_EN
    add(S_EN|S_CALL,              32'h80, 0,  32'h80,  1, 0, 0);
    add(S_EN|S_CALL,              32'h90, 0,  32'h90,  2, 0, 0);
    add(S_EN|S_RET,               0, 0,       32'h81,  1, 0, 0);
    add(S_EN|S_RET,               0, 0,       32'h11,  0, 0, 0);
    add(S_EN|S_CALL,              32'hA0, 0,  32'hA0,  1, 0, 0);
    add(S_EN|S_CALL,              32'hB0, 0,  32'hB0,  2, 0, 0);
    add(S_EN|S_CALL,              32'hC0, 0,  32'hC0,  3, 0, 0);
    add(S_EN|S_CALL,              32'hD0, 0,  32'hD0,  4, 0, 0);
    add(S_EN|S_CALL,              32'hE0, 0,  32'hE0,  4, 1, 0);
    add(S_EN|S_RET,               0, 0,       32'hD1,  3, 1, 0);
    add(S_EN|S_RET,               0, 0,       32'hC1,  2, 1, 0);
    add(S_EN|S_RET,               0, 0,       32'hB1,  1, 1, 0);
    add(S_EN|S_RET,               0, 0,       32'hA1,  0, 1, 0);
    add(S_EN|S_RET,               0, 0,       32'hA2,  0, 1, 1);
    add(S_EN|S_LD,                32'h54, 0,  32'h54,  0, 1, 1);
    add(S_EN|S_CALL,              32'h300, 0, 32'h300, 1, 1, 1);
    add(S_EN|S_CALL|S_RET,        32'h999, 0, 32'h55,  0, 1, 1);
    add(S_EN|S_LD|S_INC,          32'h400, 0, 32'h400, 0, 1, 1);
    add(S_EN|S_CALL,              32'h500, 0, 32'h500, 1, 1, 1);
    add(S_CLR|S_EN|S_CALL,        32'h600, 0, 32'h100, 0, 0, 0);
    add(S_RET,                    0, 0,       32'h100, 0, 0, 0);
    add(S_EN|S_CALL|S_LD|S_BR|S_BC, 32'h700, 16'h0010, 32'h700, 1, 0, 0);
    add(S_CALL,                   32'h800, 0, 32'h700, 1, 0, 0);
    add(S_EN|S_LD|S_BR|S_BC,      32'h800, 16'h0010, 32'h800, 1, 0, 0);
    add(S_EN|S_BR|S_BC|S_INC,     0, 16'h0010, 32'h810, 1, 0, 0);
    add(S_EN|S_RET,               0, 0,       32'h101, 0, 0, 0);
`else
    add(S_EN|S_CALL,              32'h40, 0,  32'h40,  0, 0, 0);
    add(S_EN|S_RET|S_INC,         0, 0,       32'h41,  0, 0, 0);
    add(S_EN|S_RET,               0, 0,       32'h41,  0, 0, 0);
    add(S_EN|S_RET|S_LD,          32'h60, 0,  32'h60,  0, 0, 0);
    add(S_EN|S_RET|S_BR|S_BC,     0, 16'h0002, 32'h62, 0, 0, 0);
    add(S_EN|S_CALL|S_RET,        32'h70, 0,  32'h70,  0, 0, 0);
    add(S_CALL,                   32'h90, 0,  32'h70,  0, 0, 0);
    add(S_CLR|S_EN|S_CALL,        32'h90, 0,  32'h100, 0, 0, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Negative branch below zero and forward branch across the wrap point.
    apply(mk(S_CLR,          0, 0,         32'h100,      0, 0, 0));
    apply(mk(S_EN|S_LD,      32'h5, 0,     32'h5,        0, 0, 0));
    apply(mk(S_EN|S_BR|S_BC, 0, 16'hFFF0,  32'hFFFFFFF5, 0, 0, 0));
    apply(mk(S_EN|S_BR|S_BC, 0, 16'h000B,  32'h0,        0, 0, 0));

`ifdef PC_RAS_EN
    // Six back-to-back calls overwrite the two oldest slots, then unwind.
    apply(mk(S_CLR, 0, 0, 32'h100, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      apply(mk(S_EN|S_CALL, 32'h1000 + 32'(i) * 32'h10, 0, 32'h1000 + 32'(i) * 32'h10,
               (i >= 3) ? 3'd4 : 3'(i + 1), (i >= 4), 1'b0));
    for (int j = 0; j < 4; j++)
      apply(mk(S_EN|S_RET, 0, 0, 32'h1041 - 32'(j) * 32'h10, 3'(3 - j), 1'b1, 1'b0));
    apply(mk(S_EN|S_RET, 0, 0, 32'h1012, 0, 1, 1));
`else
    apply(mk(S_EN|S_CALL, 32'hABC, 0, 32'hABC, 0, 0, 0));
    apply(mk(S_EN|S_CALL, 32'hDEF, 0, 32'hDEF, 0, 0, 0));
    apply(mk(S_EN|S_RET,  0, 0,       32'hDEF, 0, 0, 0));
`endif

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    n_checks++;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
